fetch_prefetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue. It sits directly upstream of the F/D pipeline register, replacing the bare PC-plus-ROM fetch.
- Owns the fetch PC and issues reads to a synchronous instruction memory.
- Buffers returned words with their PCs.
- Presents one instruction per cycle to decode, honouring decode stall and execute-stage redirect (branch/jump taken).

---
 rtl/fetch_prefetch_unit_if.sv | 24 ++
 rtl/fetch_prefetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bus: redirect/stall from the pipeline, instruction memory port,
// and the head-of-queue instruction presented to decode.
interface fetch_prefetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] InstrF_o;
  logic [31:0] PCF_o;
  logic [31:0] PCPlus4F_o;
  logic        ValidF_o;

  modport slave (
    input  redirect_i, redirect_pc_i, stall_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, InstrF_o, PCF_o, PCPlus4F_o, ValidF_o
  );

  modport master (
    output redirect_i, redirect_pc_i, stall_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, InstrF_o, PCF_o, PCPlus4F_o, ValidF_o
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with a DEPTH-entry prefetch queue in front of decode.
// Optional PREFETCH_PERF_EN adds perf_empty_o, a saturating empty-cycle counter.
module fetch_prefetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        rst,
  fetch_prefetch_unit_if.slave        bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]                 perf_empty_o
`endif
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic          head_valid;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [31:0]   head_pc;

  // Outstanding read counts against capacity so a response always has a slot.
  assign occupancy  = {1'b0, count_q} + (CW + 1)'(inflight_q);
  assign issue      = !rst && !bus.redirect_i && (occupancy < (CW + 1)'(DEPTH));
  assign head_valid = !rst && (count_q != '0);
  assign pop        = head_valid && !bus.stall_i && !bus.redirect_i;
  assign push       = !rst && !bus.redirect_i && inflight_q;

  assign head_pc         = head_valid ? pc_q[head_q] : 32'd0;
  assign bus.ValidF_o    = head_valid;
  assign bus.PCF_o       = head_pc;
  assign bus.PCPlus4F_o  = head_pc + 32'd4;
  assign bus.InstrF_o    = head_valid ? instr_q[head_q] : NOP_INSTR;
  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = rst ? RESET_PC : fetch_pc_q;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fetch_pc_d    = fetch_pc_q;
    if (bus.redirect_i) begin
      // Flush wins over stall and over the response in flight.
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      fetch_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
    end else begin
      if (pop)  head_d = head_q + AW'(1);
      if (push) tail_d = tail_q + AW'(1);
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  // Queue payload needs no reset: entries are only observed through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail_q] <= bus.imem_rdata_i;
      pc_q[tail_q]    <= inflight_pc_q;
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (!head_valid && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= 32'd0;
    else     perf_q <= perf_d;
  end

  assign perf_empty_o = perf_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: queue-level reference model checked
// every cycle, plus hand-computed expectations along the stimulus script.
module tb_fetch_prefetch_unit;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus();

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_empty;
`endif

  fetch_prefetch_unit #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_empty_o(perf_empty)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory content is a function of the address so instr and PC are distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_rdata_i <= mem_word(bus.imem_addr_o);
    else                bus.imem_rdata_i <= 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected decode stream as a queue of PCs.
  logic [31:0] m_q[$];
  logic        m_infl     = 1'b0;
  logic [31:0] m_infl_pc  = 32'd0;
  logic [31:0] m_fpc      = RESET_PC;
  logic [31:0] m_perf     = 32'd0;
  int          m_cyc      = 0;
  logic        e_valid, e_req;
  logic [31:0] e_pc, e_addr;

  always @(negedge clk) begin
    e_valid = !rst && (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0] : 32'd0;
    e_req   = !rst && !bus.redirect_i && ((m_q.size() + int'(m_infl)) < DEPTH);
    e_addr  = rst ? RESET_PC : m_fpc;
    if (m_cyc > 0) begin
      chk("model_valid", {31'd0, bus.ValidF_o}, {31'd0, e_valid});
      chk("model_pc",    bus.PCF_o,      e_pc);
      chk("model_pc4",   bus.PCPlus4F_o, e_pc + 32'd4);
      chk("model_instr", bus.InstrF_o,   e_valid ? mem_word(e_pc) : NOP_INSTR);
      chk("model_req",   {31'd0, bus.imem_req_o}, {31'd0, e_req});
      chk("model_addr",  bus.imem_addr_o, e_addr);
`ifdef PREFETCH_PERF_EN
      chk("model_perf",  perf_empty, m_perf);
`endif
    end
    m_cyc++;
    if (rst) begin
      m_q.delete();
      m_infl = 1'b0;
      m_fpc  = RESET_PC;
      m_perf = 32'd0;
    end else begin
      if (!e_valid && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      if (bus.redirect_i) begin
        m_q.delete();
        m_infl = 1'b0;
        m_fpc  = {bus.redirect_pc_i[31:2], 2'b00};
      end else begin
        if (e_valid && !bus.stall_i) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl = e_req;
        if (e_req) begin
          m_infl_pc = m_fpc;
          m_fpc     = m_fpc + 32'd4;
        end
      end
    end
  end

  // One cycle: drive after the edge, check literal expectation mid-cycle.
  task automatic step(input logic r, input logic red, input logic [31:0] rpc,
                      input logic st, input logic cv, input logic ev,
                      input logic [31:0] ep);
    @(posedge clk);
    #1;
    rst               = r;
    bus.redirect_i    = red;
    bus.redirect_pc_i = rpc;
    bus.stall_i       = st;
    @(negedge clk);
    if (cv) begin
      chk("lit_valid", {31'd0, bus.ValidF_o}, {31'd0, ev});
      if (ev) begin
        chk("lit_pc",  bus.PCF_o,      ep);
        chk("lit_pc4", bus.PCPlus4F_o, ep + 32'd4);
      end
    end
  endtask

  initial begin
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.stall_i       = 1'b0;

    repeat (3) step(1, 0, 0, 0, 1, 0, 0);
    chk("rst_instr", bus.InstrF_o,    NOP_INSTR);
    chk("rst_pc",    bus.PCF_o,       32'd0);
    chk("rst_pc4",   bus.PCPlus4F_o,  32'd4);
    chk("rst_req",   {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr",  bus.imem_addr_o, RESET_PC);

    // Cold start: first word valid two cycles after its request.
    step(0, 0, 0, 0, 1, 0, 0);
    chk("c0_req",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("c0_addr", bus.imem_addr_o, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'd0);

    // Stall holds head at 4 while the queue fills; request stops when full.
    repeat (6) step(0, 0, 0, 1, 1, 1, 32'd4);
    chk("full_req", {31'd0, bus.imem_req_o}, 32'd0);
    for (int k = 1; k <= 5; k++) step(0, 0, 0, 0, 1, 1, 32'(4 * k));

    // Redirect with a read in flight; old head still visible in cycle N.
    step(0, 1, 32'h0000_0103, 0, 1, 1, 32'd24);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("redir_req",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("redir_addr", bus.imem_addr_o, 32'h0000_0100);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h0000_0100);
    chk("redir_instr", bus.InstrF_o, 32'h5A5A_0100);

    // Fill under stall, then redirect+stall together.
    repeat (5) step(0, 0, 0, 1, 1, 1, 32'h0000_0104);
    step(0, 1, 32'h0000_0200, 1, 1, 1, 32'h0000_0104);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h0000_0200);
    step(0, 0, 0, 0, 1, 1, 32'h0000_0204);

    // Redirect near the top of the address space; low bits ignored, PC wraps.
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.PCPlus4F_o, 32'd0);
    step(0, 0, 0, 0, 1, 1, 32'd0);

    // Reset pulse with a read in flight.
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("rst2_req",  {31'd0, bus.imem_req_o}, 32'd1);
    chk("rst2_addr", bus.imem_addr_o, RESET_PC);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'd0);
`ifdef PREFETCH_PERF_EN
    chk("perf_after_rst", perf_empty, 32'd2);
`endif
    step(0, 0, 0, 0, 1, 1, 32'd4);
    step(0, 0, 0, 0, 1, 1, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
